// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Valid/ready word stream that feeds the UART transmitter's input FIFO.
//   Data_in    : word to transmit, LSB goes out first
//   Data_valid : producer has a word on Data_in
//   Data_ready : transmitter FIFO can take a word (not full)
// A word is transferred on a rising clock edge where Data_valid & Data_ready.
// Modports: master = word producer, slave = uart_tx_param.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data_in;
    logic              Data_valid;
    logic              Data_ready;

    modport master (
        output Data_in,
        output Data_valid,
        input  Data_ready
    );

    modport slave (
        input  Data_in,
        input  Data_valid,
        output Data_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with an input FIFO, run-time data length
// (1..DATA_W bits) and one or two stop bits. Bit timing comes from Tick, a
// one-cycle enable that must pulse OVERSAMPLE times per bit period.
//
// Ports:
//   Clock, Reset_n : rising-edge clock, asynchronous active-low reset
//   Tick           : baud x OVERSAMPLE enable
//   in_if (slave)  : Data_in / Data_valid / Data_ready word stream
//   N_bits         : data bits per frame (0 or >DATA_W means DATA_W)
//   Two_stop       : 1 = two stop bits
//   Parity_en, Parity_odd : only when UART_TX_PARITY_EN is defined
//   Tx_out         : serial line, idles high, driven from a register
//   Busy           : high from frame start to the end of the last stop bit
//   Tx_done        : one-cycle pulse at the end of each frame
//   Fifo_count     : words currently held in the FIFO
//
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data.
// N_bits, Two_stop and the parity controls are latched when a word is popped.
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        Tick,
    uart_tx_param_if.slave              in_if,
    input  logic [4:0]                  N_bits,
    input  logic                        Two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic                        Parity_en,
    input  logic                        Parity_odd,
`endif
    output logic                        Tx_out,
    output logic                        Busy,
    output logic                        Tx_done,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- input FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              full_reg;
    logic              push, pop;

    // Ready comes straight from the registered full flag, so a full FIFO
    // refuses a push even when a pop frees a slot in the same cycle.
    assign push             = in_if.Data_valid & ~full_reg;
    assign in_if.Data_ready = ~full_reg;
    assign Fifo_count       = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr_reg] <= in_if.Data_in;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    // ---------------- transmit FSM ----------------
    state_t            state_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic [4:0]        bit_cnt_reg;
    logic [4:0]        n_eff_reg;
    logic [4:0]        n_sel;
    logic              two_stop_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              tx_reg, busy_reg, done_reg;
    logic              bit_end, last_stop, fifo_nonempty;
`ifdef UART_TX_PARITY_EN
    logic              parity_en_reg;
    logic              parity_acc_reg;
`endif

    // Out-of-range lengths fall back to the full word width.
    always_comb begin
        n_sel = N_bits;
        if (N_bits == 5'd0 || int'(N_bits) > DATA_W) n_sel = 5'(DATA_W);
    end

    assign fifo_nonempty = (count_reg != '0);
    assign bit_end       = Tick && (state_reg != IDLE) &&
                           (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1));
    assign last_stop     = (bit_cnt_reg == {4'd0, two_stop_reg});
    assign pop           = fifo_nonempty &&
                           ((state_reg == IDLE) ||
                            (state_reg == STOP && bit_end && last_stop));

    assign Tx_out  = tx_reg;
    assign Busy    = busy_reg;
    assign Tx_done = done_reg;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            n_eff_reg      <= '0;
            two_stop_reg   <= 1'b0;
            shift_reg      <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_reg  <= 1'b0;
            parity_acc_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (Tick && state_reg != IDLE)
                tick_cnt_reg <= bit_end ? '0 : tick_cnt_reg + 1'b1;

            case (state_reg)
                IDLE: ;   // leaving IDLE is handled by the pop block below
                START: begin
                    if (bit_end) begin
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                        bit_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
`ifdef UART_TX_PARITY_EN
                        parity_acc_reg <= parity_acc_reg ^ shift_reg[0];
`endif
                        if (bit_cnt_reg == n_eff_reg - 5'd1) begin
                            bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            if (parity_en_reg) begin
                                state_reg <= PARITY;
                                tx_reg    <= parity_acc_reg ^ shift_reg[0];
                            end else begin
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
                            end
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            // next bit to go out is the one that becomes bit 0
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            done_reg <= 1'b1;
                            if (!fifo_nonempty) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Frame start: from IDLE, or straight out of the last stop bit so
            // back-to-back frames have no idle gap. A Tick here is not counted.
            if (pop) begin
                shift_reg    <= mem[rd_ptr_reg];
                n_eff_reg    <= n_sel;
                two_stop_reg <= Two_stop;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                state_reg    <= START;
                tx_reg       <= 1'b0;
                busy_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_en_reg  <= Parity_en;
                parity_acc_reg <= Parity_odd;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Directed scenarios plus a randomised run for uart_tx_param. A frame-level
// reference model (word queue, per-frame bit list, Tick count into the frame)
// predicts Tx_out/Busy/Tx_done/Fifo_count/Data_ready every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_param;
    localparam int DATA_W = 8;
    localparam int OS     = 16;
    localparam int DEPTH  = 4;

    logic Clock = 1'b0;
    logic Reset_n;
    logic Tick;
    logic [4:0] N_bits;
    logic Two_stop;
`ifdef UART_TX_PARITY_EN
    logic Parity_en;
    logic Parity_odd;
`endif
    logic Tx_out, Busy, Tx_done;
    logic [$clog2(DEPTH):0] Fifo_count;

    uart_tx_param_if #(.DATA_W(DATA_W)) bus();

    uart_tx_param #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Tick       (Tick),
        .in_if      (bus),
        .N_bits     (N_bits),
        .Two_stop   (Two_stop),
`ifdef UART_TX_PARITY_EN
        .Parity_en  (Parity_en),
        .Parity_odd (Parity_odd),
`endif
        .Tx_out     (Tx_out),
        .Busy       (Busy),
        .Tx_done    (Tx_done),
        .Fifo_count (Fifo_count)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];
    bit          m_active = 1'b0;
    int          m_ticks  = 0;
    int          m_len    = 0;     // frame length in bit periods
    logic [31:0] m_bits   = '1;    // bit i is the line level during bit period i
    bit          m_done   = 1'b0;

    task automatic build_frame(input logic [DATA_W-1:0] d, input logic [4:0] nb,
                               input bit ts, input bit pe, input bit po,
                               output logic [31:0] bits, output int len);
        int  n;
        bit  p;
        n    = (nb == 0 || int'(nb) > DATA_W) ? DATA_W : int'(nb);
        bits = '1;
        bits[0] = 1'b0;
        p = po;
        for (int i = 0; i < n; i++) begin
            bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        len = 1 + n + (ts ? 2 : 1);
        if (pe) begin
            bits[1 + n] = p;
            len++;
        end
    endtask

    task automatic model_step();
        int pre_cnt;
        bit do_pop;
        bit pe, po;
        logic [DATA_W-1:0] w;
        pe = 1'b0;
        po = 1'b0;
`ifdef UART_TX_PARITY_EN
        pe = Parity_en;
        po = Parity_odd;
`endif
        pre_cnt = mq.size();
        m_done  = 1'b0;
        do_pop  = 1'b0;
        if (!m_active) begin
            if (pre_cnt != 0) do_pop = 1'b1;
        end else if (Tick) begin
            m_ticks++;
            if (m_ticks == m_len * OS) begin
                m_done   = 1'b1;
                m_active = 1'b0;
                if (pre_cnt != 0) do_pop = 1'b1;
            end
        end
        if (do_pop) begin
            w = mq.pop_front();
            build_frame(w, N_bits, Two_stop, pe, po, m_bits, m_len);
            m_active = 1'b1;
            m_ticks  = 0;
        end
        if (bus.Data_valid && pre_cnt < DEPTH) mq.push_back(bus.Data_in);
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            if (!Reset_n) begin
                mq.delete();
                m_active = 1'b0;
                m_ticks  = 0;
                m_done   = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                check("rst_tx",    Tx_out,          1);
                check("rst_busy",  Busy,            0);
                check("rst_done",  Tx_done,         0);
                check("rst_count", Fifo_count,      0);
                check("rst_ready", bus.Data_ready,  1);
            end else begin
                check("tx",    Tx_out,         m_active ? m_bits[m_ticks / OS] : 1'b1);
                check("busy",  Busy,           m_active);
                check("done",  Tx_done,        m_done);
                check("count", Fifo_count,     mq.size());
                check("ready", bus.Data_ready, mq.size() < DEPTH);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic samp[$];

    task automatic push_word(input logic [DATA_W-1:0] d);
        bus.Data_valid = 1'b1;
        bus.Data_in    = d;
        @(negedge Clock);
        bus.Data_valid = 1'b0;
    endtask

    // Counts contiguous busy cycles and Tx_done pulses, recording Tx_out.
    task automatic measure_busy(input int budget, output int busy_cycles, output int dones);
        bit started;
        busy_cycles = 0;
        dones       = 0;
        started     = 1'b0;
        samp.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge Clock);
            if (Tx_done) dones++;
            if (Busy) begin
                started = 1'b1;
                busy_cycles++;
                samp.push_back(Tx_out);
            end else if (started) begin
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    bit exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int bc, dn;
        bit drained;
        Reset_n        = 1'b0;
        Tick           = 1'b0;
        N_bits         = 5'd8;
        Two_stop       = 1'b0;
        bus.Data_valid = 1'b0;
        bus.Data_in    = '0;
`ifdef UART_TX_PARITY_EN
        Parity_en  = 1'b0;
        Parity_odd = 1'b0;
`endif
        repeat (3) @(negedge Clock);
        check("init_tx",    Tx_out, 1);
        check("init_ready", bus.Data_ready, 1);
        Reset_n = 1'b1;
        @(negedge Clock);
        Tick = 1'b1;

        // Single 8'hA5 frame, 8N1
        push_word(8'hA5);
        measure_busy(1000, bc, dn);
        check("a5_busy_cycles", bc, 160);
        check("a5_done_count",  dn, 1);
        for (int i = 0; i < 10; i++)
            check($sformatf("a5_bit%0d", i), samp[8 + OS * i], exp_a5[i]);

        // Three back-to-back frames with two stop bits
        Two_stop = 1'b1;
        fork
            begin
                push_word(8'h3C);
                push_word(8'hC3);
                push_word(8'hFF);
            end
            measure_busy(3000, bc, dn);
        join
        check("b2b_busy_cycles", bc, 3 * 176);
        check("b2b_done_count",  dn, 3);
        Two_stop = 1'b0;

        // FIFO full with Tick stalled: one frame in flight, five more offered
        push_word(8'h11);
        @(negedge Clock);
        Tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.Data_valid = 1'b1;
            bus.Data_in    = 8'(8'h20 + i);
            @(negedge Clock);
        end
        bus.Data_valid = 1'b0;
        check("full_count", Fifo_count, 4);
        check("full_ready", bus.Data_ready, 0);
        Tick = 1'b1;
        measure_busy(5000, bc, dn);
        check("full_frames", dn, 5);

        // Run-time length: 5 bits, then 0 (meaning full width)
        fork
            begin
                N_bits = 5'd5;
                push_word(8'h1F);
                @(negedge Clock);
                N_bits = 5'd0;
                push_word(8'h80);
            end
            measure_busy(2000, bc, dn);
        join
        check("nbits_busy_cycles", bc, 7 * OS + 10 * OS);
        check("nbits_done_count",  dn, 2);
        N_bits = 5'd8;

`ifdef UART_TX_PARITY_EN
        Parity_en  = 1'b1;
        Parity_odd = 1'b0;
        push_word(8'h07);
        measure_busy(1000, bc, dn);
        check("par_even_cycles", bc, 176);
        check("par_even_bit",    samp[9 * OS + 8], 1);
        Parity_odd = 1'b1;
        push_word(8'h07);
        measure_busy(1000, bc, dn);
        check("par_odd_cycles", bc, 176);
        check("par_odd_bit",    samp[9 * OS + 8], 0);
        Parity_en  = 1'b0;
        Parity_odd = 1'b0;
`endif

        // Asynchronous reset during data bit 3 of 8'h55 (bit 3 is 0)
        push_word(8'h55);
        push_word(8'h33);
        repeat (72) @(negedge Clock);
        check("pre_rst_tx",    Tx_out, 0);
        check("pre_rst_count", Fifo_count, 1);
        @(posedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_tx",    Tx_out, 1);
        check("async_rst_busy",  Busy, 0);
        check("async_rst_count", Fifo_count, 0);
        check("async_rst_done",  Tx_done, 0);
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;

        // Randomised traffic, config changes mid-frame, irregular Tick
        for (int c = 0; c < 7000; c++) begin
            @(negedge Clock);
            Tick           = ($urandom_range(0, 3) != 0);
            bus.Data_valid = ($urandom_range(0, 2) == 0);
            bus.Data_in    = DATA_W'($urandom);
            if ($urandom_range(0, 15) == 0) N_bits   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) Two_stop = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
            if ($urandom_range(0, 15) == 0) Parity_en  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) Parity_odd = 1'($urandom_range(0, 1));
`endif
        end
        @(negedge Clock);
        bus.Data_valid = 1'b0;
        Tick = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge Clock);
            if (!Busy && Fifo_count == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_idle", drained, 1);
        repeat (2) @(negedge Clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8-bit UART transmit block in UART_Comms.
- Single clock domain; baud timing from a `Tick` enable pulse that is synchronous to `Clock`.
- Adds an input FIFO with valid/ready handshake, run-time data length, and 1 or 2 stop bits.
- Supports back-to-back frames; sits between the crypto core's output stream and the Tx pin.

Parameters:
- DATA_W, 8: maximum data bits per frame (legal 5..16).
- OVERSAMPLE, 16: Tick pulses per bit period (legal 4..64).
- FIFO_DEPTH, 4: input FIFO entries (power of two, 2..64).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Tick  in  1  baud x OVERSAMPLE enable; one Clock cycle wide; counted only when high.
- Data_in  in  DATA_W  word to transmit; LSB sent first.
- Data_valid  in  1  Data_in is valid.
- Data_ready  out  1  FIFO can accept a word; equals not-full.
- N_bits  in  5  data bits per frame; sampled at frame start.
- Two_stop  in  1  1 = two stop bits; sampled at frame start.
- Tx_out  out  1  serial line; idles high.
- Busy  out  1  high from frame start until the last stop bit ends.
- Tx_done  out  1  one-Clock pulse at the end of each frame.
- Fifo_count  out  clog2(FIFO_DEPTH)+1  number of words held in the FIFO.

Behaviour:
- Reset (asynchronous, while Reset_n=0):
  - Tx_out=1, Busy=0, Tx_done=0.
  - FIFO emptied: Fifo_count=0, Data_ready=1.
  - FSM=IDLE; tick and bit counters cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high.
- Handshake:
  - A push occurs on a Clock edge where Data_valid & Data_ready.
  - Data_ready is from registered full. At full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves Fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the option below).
- IDLE:
  - When FIFO non-empty: pop the head into the shift register.
  - Latch N_bits and Two_stop; clear tick_cnt and bit_cnt.
  - Go to START next cycle.
- Config rules:
  - Latched N_bits of 0 or greater than DATA_W uses DATA_W.
  - Values 1..4 are used as given.
- Bit period: every state holds Tx_out for exactly OVERSAMPLE Tick pulses.
  - tick_cnt increments on each Tick.
  - On the Tick where tick_cnt==OVERSAMPLE-1, the bit ends and tick_cnt wraps to 0.
- START: Tx_out=0; at bit end go to DATA.
- DATA:
  - Tx_out = shift register bit 0; shift right at each bit end.
  - bit_cnt counts 0..N-1; after bit N-1 go to STOP.
- STOP:
  - Tx_out=1 for 1 or 2 bit periods per latched Two_stop.
  - At the final bit end, Tx_done pulses for one cycle.
  - If the FIFO is non-empty: pop and go directly to START, with no idle gap and Busy held high.
  - Otherwise go to IDLE and drop Busy.
- Latency: with the FIFO empty and IDLE, a push on cycle k gives pop on k+1, Tx_out=0 and Busy=1 from k+2.
- Frame length is (1 + N + stop bits) x OVERSAMPLE Ticks, ignoring the two-cycle start latency.
- Tick arriving in the same cycle as a pop/START entry is not counted.
- Data_in and N_bits changes mid-frame do not affect the frame in flight.
- Tx_out is driven from a register (glitch-free).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - Adds ports Parity_en (in, 1) and Parity_odd (in, 1), latched at frame start.
  - If latched Parity_en=1, a PARITY state follows DATA for one bit period.
  - Parity bit = XOR of the N data bits, inverted if Parity_odd.
  - Frame grows by OVERSAMPLE Ticks.
- When undefined: ports absent, no PARITY state, frame as above.

Test Plan:
- Reset then idle, OVERSAMPLE=16, N_bits=8, Two_stop=0, push 8'hA5 → Tx_out 0 for 16 Ticks, then 1,0,1,0,0,1,0,1, then 1 for 16 Ticks; Tx_done once; total 160 Ticks.
- Push 8'h3C,8'hC3,8'hFF back-to-back with Two_stop=1 → three contiguous frames, no gap; each 176 Ticks; Busy high throughout; three Tx_done pulses.
- FIFO_DEPTH=4 with Tick held low: push 5 words → Data_ready=0 after the 4th; 5th not accepted; Fifo_count=4.
- N_bits=5, push 8'h1F; then N_bits=0, push 8'h80 → frame 1 has 5 data bits of 1; frame 2 has 8 bits, MSB=1.
- Assert Reset_n=0 during data bit 3 → Tx_out=1 and Busy=0 immediately; Fifo_count=0; no Tx_done.
- With UART_TX_PARITY_EN: Parity_en=1, Parity_odd=0, push 8'h07 → parity bit 1; with Parity_odd=1 → parity bit 0; frame 176 Ticks.
